// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm editor: FSM states, field codes and BCD limits.
// Pure declarations; no timing or flow control.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;
  localparam int         NUM_ALARMS = 3;

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_H) || (s == ST_EDIT_M) || (s == ST_EDIT_S);
  endfunction

  function automatic logic [1:0] state_field(input state_e s);
    case (s)
      ST_EDIT_H: return FIELD_H;
      ST_EDIT_M: return FIELD_M;
      ST_EDIT_S: return FIELD_S;
      default:   return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_wrap_step.sv
// Combinational BCD +1/-1 with wrap between 00 and max_i; zero latency.
// Invalid BCD or out-of-range input snaps to 00 on any step request.
module bcd_wrap_step (
  input  logic [7:0] value_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [7:0] next_o
);

  logic valid;

  always_comb begin
    valid  = (value_i[7:4] <= 4'd9) && (value_i[3:0] <= 4'd9) && (value_i <= max_i);
    next_o = value_i;
    if (up_i || down_i) begin
      if (!valid) begin
        next_o = 8'h00;
      end else if (up_i) begin
        if (value_i == max_i)            next_o = 8'h00;
        else if (value_i[3:0] == 4'd9)   next_o = {value_i[7:4] + 4'd1, 4'd0};
        else                             next_o = value_i + 8'd1;
      end else begin
        if (value_i == 8'h00)            next_o = max_i;
        else if (value_i[3:0] == 4'd0)   next_o = {value_i[7:4] - 4'd1, 4'd9};
        else                             next_o = value_i - 8'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_editor.sv
// Button-driven alarm editor: loads readback, edits H/M/S in BCD, commits with a one-cycle set.
// All outputs registered; set rises the cycle after btn_mode in EDIT_S.
module alarm_editor
  import alarm_pkg::*;
#(
  parameter int LOAD_WAIT      = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_HALF     = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_next,
  input  logic        btn_abort,
  input  logic [15:0] cur_year_bcd,
  input  logic [7:0]  cur_month_bcd,
  input  logic [7:0]  cur_day_bcd,
  input  logic [7:0]  rd_hour_bcd,
  input  logic [7:0]  rd_minute_bcd,
  input  logic [7:0]  rd_second_bcd,
  output logic [1:0]  selected_alarm,
  output logic        set,
  output logic [15:0] alarm_year_bcd_in,
  output logic [7:0]  alarm_month_bcd_in,
  output logic [7:0]  alarm_day_bcd_in,
  output logic [7:0]  alarm_hour_bcd_in,
  output logic [7:0]  alarm_minute_bcd_in,
  output logic [7:0]  alarm_second_bcd_in,
  output logic        editing,
  output logic [1:0]  field,
  output logic        blink
);

  localparam int LW = $clog2(LOAD_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  state_e         state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic           set_q, set_d;
  logic [15:0]    year_q, year_d;
  logic [7:0]     month_q, month_d, day_q, day_d;
  logic [7:0]     hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic           editing_q, editing_d;
  logic [1:0]     field_q, field_d;
  logic           blink_q, blink_d;
  logic [LW-1:0]  wait_q, wait_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;

  logic           step_up, step_dn, any_btn;
  logic [7:0]     step_in, step_max, step_out;

  // One stepper shared by all three fields, selected by the current edit state.
  always_comb begin
    case (state_q)
      ST_EDIT_H: step_in = hour_q;
      ST_EDIT_M: step_in = min_q;
      default:   step_in = sec_q;
    endcase
    step_max = (state_q == ST_EDIT_H) ? HOUR_MAX : MINSEC_MAX;
  end

  bcd_wrap_step u_step (
    .value_i (step_in),
    .max_i   (step_max),
    .up_i    (step_up),
    .down_i  (step_dn),
    .next_o  (step_out)
  );

  always_comb begin
    any_btn = btn_mode | btn_up | btn_down | btn_next | btn_abort;
    state_d = state_q;
    sel_d   = sel_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    wait_d  = '0;
    step_up = 1'b0;
    step_dn = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_abort) begin
          state_d = ST_IDLE;
        end else if (btn_mode) begin
          state_d = ST_LOAD;
          year_d  = cur_year_bcd;
          month_d = cur_month_bcd;
          day_d   = cur_day_bcd;
        end else if (btn_next) begin
          sel_d = (sel_q == 2'(NUM_ALARMS - 1)) ? 2'd0 : sel_q + 2'd1;
        end
      end
      ST_LOAD: begin
        if (btn_abort) begin
          state_d = ST_IDLE;
        end else if (wait_q == LW'(LOAD_WAIT - 1)) begin
          state_d = ST_EDIT_H;
          hour_d  = rd_hour_bcd;
          min_d   = rd_minute_bcd;
          sec_d   = rd_second_bcd;
        end else begin
          wait_d = wait_q + LW'(1);
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        if (btn_abort) begin
          state_d = ST_IDLE;
        end else if (btn_mode) begin
          case (state_q)
            ST_EDIT_H: state_d = ST_EDIT_M;
            ST_EDIT_M: state_d = ST_EDIT_S;
            default:   state_d = ST_COMMIT;
          endcase
        end else if (btn_up) begin
          step_up = 1'b1;
        end else if (btn_down) begin
          step_dn = 1'b1;
        end else if (!any_btn && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (step_up || step_dn) begin
      case (state_q)
        ST_EDIT_H: hour_d = step_out;
        ST_EDIT_M: min_d  = step_out;
        default:   sec_d  = step_out;
      endcase
    end

    if (!is_edit(state_d) || any_btn || state_d != state_q) tmo_d = '0;
    else                                                     tmo_d = tmo_q + TW'(1);

    // Field entry and every edit restart the blink phase so the new value is visible.
    if (!is_edit(state_d) || state_d != state_q || step_up || step_dn) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q + BW'(1);
    end

    set_d     = (state_d == ST_COMMIT);
    editing_d = (state_d != ST_IDLE);
    field_d   = state_field(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      set_q     <= 1'b0;
      year_q    <= '0;
      month_q   <= '0;
      day_q     <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      editing_q <= 1'b0;
      field_q   <= FIELD_NONE;
      blink_q   <= 1'b1;
      wait_q    <= '0;
      tmo_q     <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      set_q     <= set_d;
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      editing_q <= editing_d;
      field_q   <= field_d;
      blink_q   <= blink_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign selected_alarm      = sel_q;
  assign set                 = set_q;
  assign alarm_year_bcd_in   = year_q;
  assign alarm_month_bcd_in  = month_q;
  assign alarm_day_bcd_in    = day_q;
  assign alarm_hour_bcd_in   = hour_q;
  assign alarm_minute_bcd_in = min_q;
  assign alarm_second_bcd_in = sec_q;
  assign editing             = editing_q;
  assign field               = field_q;
  assign blink               = blink_q;

endmodule

// File: tb/tb_alarm_editor.sv
// Directed bench for alarm_editor: table of button vectors with hand-computed results,
// plus hand sequences for reset, timeout, blink and mid-edit reset.
module tb_alarm_editor;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_NX   = 5'b00001;
  localparam logic [4:0] B_DN   = 5'b00010;
  localparam logic [4:0] B_UP   = 5'b00100;
  localparam logic [4:0] B_MODE = 5'b01000;
  localparam logic [4:0] B_ABT  = 5'b10000;

  logic        clk, rst_n;
  logic [4:0]  btn;
  logic        btn_mode, btn_up, btn_down, btn_next, btn_abort;
  logic [15:0] cur_year_bcd;
  logic [7:0]  cur_month_bcd, cur_day_bcd;
  logic [7:0]  rd_hour_bcd, rd_minute_bcd, rd_second_bcd;
  logic [1:0]  selected_alarm;
  logic        set;
  logic [15:0] alarm_year_bcd_in;
  logic [7:0]  alarm_month_bcd_in, alarm_day_bcd_in;
  logic [7:0]  alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in;
  logic        editing;
  logic [1:0]  field;
  logic        blink;

  assign btn_next  = btn[0];
  assign btn_down  = btn[1];
  assign btn_up    = btn[2];
  assign btn_mode  = btn[3];
  assign btn_abort = btn[4];

  alarm_editor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .btn_mode            (btn_mode),
    .btn_up              (btn_up),
    .btn_down            (btn_down),
    .btn_next            (btn_next),
    .btn_abort           (btn_abort),
    .cur_year_bcd        (cur_year_bcd),
    .cur_month_bcd       (cur_month_bcd),
    .cur_day_bcd         (cur_day_bcd),
    .rd_hour_bcd         (rd_hour_bcd),
    .rd_minute_bcd       (rd_minute_bcd),
    .rd_second_bcd       (rd_second_bcd),
    .selected_alarm      (selected_alarm),
    .set                 (set),
    .alarm_year_bcd_in   (alarm_year_bcd_in),
    .alarm_month_bcd_in  (alarm_month_bcd_in),
    .alarm_day_bcd_in    (alarm_day_bcd_in),
    .alarm_hour_bcd_in   (alarm_hour_bcd_in),
    .alarm_minute_bcd_in (alarm_minute_bcd_in),
    .alarm_second_bcd_in (alarm_second_bcd_in),
    .editing             (editing),
    .field               (field),
    .blink               (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int set_cnt = 0;

  always @(posedge clk) if (set === 1'b1) set_cnt <= set_cnt + 1;

  typedef struct {
    logic [4:0] btn;
    int         idle;
    logic [7:0] rh, rm, rs;
    logic       ed;
    logic [1:0] fld, sel;
    logic       st;
    logic [7:0] h, m, s;
  } vec_t;

  localparam int NV = 37;
  vec_t tv[NV];

  function automatic vec_t mk(input logic [4:0] b, input int idle,
                              input logic [23:0] rd, input logic ed,
                              input logic [1:0] fld, input logic [1:0] sel,
                              input logic st, input logic [23:0] hms);
    vec_t v;
    v.btn = b;  v.idle = idle;
    v.rh = rd[23:16]; v.rm = rd[15:8]; v.rs = rd[7:0];
    v.ed = ed;  v.fld = fld; v.sel = sel; v.st = st;
    v.h = hms[23:16]; v.m = hms[15:8]; v.s = hms[7:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] m);
    btn = m;
    step();
    btn = B_NONE;
  endtask

  task automatic enter_edit_h();
    pulse(B_MODE);
    repeat (4) step();
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_ctl"}, 64'({editing, field, selected_alarm, set, blink}), 64'(7'b0_00_00_0_1));
    check({name, "_dat"}, 64'({alarm_year_bcd_in, alarm_month_bcd_in, alarm_day_bcd_in,
                              alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in}), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    localparam logic [23:0] R1 = 24'h123456;
    localparam logic [23:0] R2 = 24'h235909;
    localparam logic [23:0] R3 = 24'h3A6009;

    tv[0]  = mk(B_NX,          0, R1, 0, 0, 1, 0, 24'h000000);
    tv[1]  = mk(B_NX,          0, R1, 0, 0, 2, 0, 24'h000000);
    tv[2]  = mk(B_NX,          0, R1, 0, 0, 0, 0, 24'h000000);
    tv[3]  = mk(B_NX,          0, R1, 0, 0, 1, 0, 24'h000000);
    tv[4]  = mk(B_MODE,        0, R1, 1, 0, 1, 0, 24'h000000);
    tv[5]  = mk(B_NONE,        2, R1, 1, 0, 1, 0, 24'h000000);
    tv[6]  = mk(B_NONE,        0, R1, 1, 1, 1, 0, 24'h123456);
    tv[7]  = mk(B_UP,          0, R1, 1, 1, 1, 0, 24'h133456);
    tv[8]  = mk(B_DN,          0, R1, 1, 1, 1, 0, 24'h123456);
    tv[9]  = mk(B_DN,          0, R1, 1, 1, 1, 0, 24'h113456);
    tv[10] = mk(B_UP | B_MODE, 0, R1, 1, 2, 1, 0, 24'h113456);
    tv[11] = mk(B_UP,          0, R1, 1, 2, 1, 0, 24'h113556);
    tv[12] = mk(B_MODE,        0, R1, 1, 3, 1, 0, 24'h113556);
    tv[13] = mk(B_DN,          0, R1, 1, 3, 1, 0, 24'h113555);
    tv[14] = mk(B_NX,          0, R1, 1, 3, 1, 0, 24'h113555);
    tv[15] = mk(B_MODE,        0, R1, 1, 0, 1, 1, 24'h113555);
    tv[16] = mk(B_NONE,        0, R1, 0, 0, 1, 0, 24'h113555);
    tv[17] = mk(B_MODE,        0, R2, 1, 0, 1, 0, 24'h113555);
    tv[18] = mk(B_NONE,        3, R2, 1, 1, 1, 0, 24'h235909);
    tv[19] = mk(B_UP,          0, R2, 1, 1, 1, 0, 24'h005909);
    tv[20] = mk(B_DN,          0, R2, 1, 1, 1, 0, 24'h235909);
    tv[21] = mk(B_MODE,        0, R2, 1, 2, 1, 0, 24'h235909);
    tv[22] = mk(B_UP,          0, R2, 1, 2, 1, 0, 24'h230009);
    tv[23] = mk(B_DN,          0, R2, 1, 2, 1, 0, 24'h235909);
    tv[24] = mk(B_UP,          0, R2, 1, 2, 1, 0, 24'h230009);
    tv[25] = mk(B_ABT,         0, R2, 0, 0, 1, 0, 24'h230009);
    tv[26] = mk(B_MODE,        0, R3, 1, 0, 1, 0, 24'h230009);
    tv[27] = mk(B_NONE,        3, R3, 1, 1, 1, 0, 24'h3A6009);
    tv[28] = mk(B_DN,          0, R3, 1, 1, 1, 0, 24'h006009);
    tv[29] = mk(B_MODE,        0, R3, 1, 2, 1, 0, 24'h006009);
    tv[30] = mk(B_UP,          0, R3, 1, 2, 1, 0, 24'h000009);
    tv[31] = mk(B_MODE,        0, R3, 1, 3, 1, 0, 24'h000009);
    tv[32] = mk(B_UP,          0, R3, 1, 3, 1, 0, 24'h000010);
    tv[33] = mk(B_ABT | B_MODE | B_UP, 0, R3, 0, 0, 1, 0, 24'h000010);
    tv[34] = mk(B_MODE,        0, R3, 1, 0, 1, 0, 24'h000010);
    tv[35] = mk(B_ABT,         0, R3, 0, 0, 1, 0, 24'h000010);
    tv[36] = mk(B_UP | B_DN,   0, R3, 0, 0, 1, 0, 24'h000010);

    btn = B_NONE;
    rst_n = 1'b0;
    cur_year_bcd = 16'h2024; cur_month_bcd = 8'h08; cur_day_bcd = 8'h30;
    rd_hour_bcd = 8'h12; rd_minute_bcd = 8'h34; rd_second_bcd = 8'h56;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    check_reset_state("after_release");

    for (int i = 0; i < NV; i++) begin
      rd_hour_bcd = tv[i].rh; rd_minute_bcd = tv[i].rm; rd_second_bcd = tv[i].rs;
      pulse(tv[i].btn);
      repeat (tv[i].idle) step();
      check($sformatf("vec%0d", i),
            64'({editing, field, selected_alarm, set,
                 alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in}),
            64'({tv[i].ed, tv[i].fld, tv[i].sel, tv[i].st, tv[i].h, tv[i].m, tv[i].s}));
      if (i == 4) begin
        cur_year_bcd = 16'h2025; cur_month_bcd = 8'h12; cur_day_bcd = 8'h31;
      end
      if (i == 6)
        check("date_latched", 64'({alarm_year_bcd_in, alarm_month_bcd_in, alarm_day_bcd_in}),
              64'(32'h2024_08_30));
    end
    check("date_relatched", 64'({alarm_year_bcd_in, alarm_month_bcd_in, alarm_day_bcd_in}),
          64'(32'h2025_12_31));
    check("set_count_table", 64'(set_cnt), 64'd1);

    // Full timeout in EDIT_S, with blink phase checks along the way.
    enter_edit_h();
    pulse(B_MODE);
    pulse(B_MODE);
    check("tmo_enter_s", 64'({editing, field, blink}), 64'(4'b1_11_1));
    repeat (249) step();
    check("blink_before_toggle", 64'(blink), 64'd1);
    step();
    check("blink_toggled", 64'(blink), 64'd0);
    repeat (749) step();
    check("tmo_last_cycle", 64'({editing, field}), 64'(3'b1_11));
    step();
    check("tmo_expired", 64'({editing, field, set}), 64'(4'b0_00_0));

    // Restart: btn_up with the counter at TIMEOUT_CYCLES-2.
    enter_edit_h();
    pulse(B_MODE);
    pulse(B_MODE);
    repeat (998) step();
    pulse(B_UP);
    check("restart_blink_forced", 64'({blink, alarm_second_bcd_in}), 64'({1'b1, 8'h10}));
    repeat (999) step();
    check("restart_still_edit", 64'({editing, field}), 64'(3'b1_11));
    step();
    check("restart_expired", 64'({editing, field, set}), 64'(4'b0_00_0));
    check("set_count_tmo", 64'(set_cnt), 64'd1);

    // Reset in the middle of EDIT_M.
    enter_edit_h();
    pulse(B_MODE);
    check("pre_reset_edit_m", 64'({editing, field, selected_alarm}), 64'(5'b1_10_01));
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_edit_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) step();
    check("post_reset_idle", 64'({editing, field, set, blink}), 64'(5'b0_00_0_1));
    check("set_count_final", 64'(set_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
